// File: rtl/cpu_cmp_pkg.sv
// Shared types for the CPU lockstep checker: the retire snapshot layout,
// the checker FSM states and the per-field diff mask bit positions.
package cpu_cmp_pkg;

   typedef struct packed {
      logic [7:0] opcode;
      logic [7:0] a;
      logic [7:0] x;
      logic [7:0] y;
   } snapshot_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FAULT = 2'd2
   } state_e;

   localparam int FLD_OPCODE = 3;
   localparam int FLD_A      = 2;
   localparam int FLD_X      = 1;
   localparam int FLD_Y      = 0;

   function automatic logic [3:0] field_diff(input snapshot_t r, input snapshot_t d);
      logic [3:0] m;
      m             = '0;
      m[FLD_OPCODE] = (r.opcode != d.opcode);
      m[FLD_A]      = (r.a != d.a);
      m[FLD_X]      = (r.x != d.x);
      m[FLD_Y]      = (r.y != d.y);
      return m;
   endfunction

endpackage

// File: rtl/cpu_cmp_fifo.sv
// Synchronous FIFO for one retire stream; an extra pointer bit separates
// full from empty, and a push into a full FIFO only lands when it pops too.
module cpu_cmp_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop && !empty && !flush;
   assign do_push = push && (!full || do_pop) && !flush;
   assign rdata   = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/cpu_lockstep_checker.sv
// In-order lockstep comparator of DUV vs reference CPU retire snapshots.
// Optional CPU_CMP_STOP_ON_MISMATCH_EN: fault on first mismatch and keep the offending pair.
module cpu_lockstep_checker
   import cpu_cmp_pkg::*;
#(
   parameter int DEPTH          = 16,
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int CNT_W          = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable_i,
   input  logic             clear_i,
   input  logic             ref_valid_i,
   input  logic [7:0]       ref_opcode_i,
   input  logic [7:0]       ref_a_i,
   input  logic [7:0]       ref_x_i,
   input  logic [7:0]       ref_y_i,
   input  logic             duv_valid_i,
   input  logic [7:0]       duv_opcode_i,
   input  logic [7:0]       duv_a_i,
   input  logic [7:0]       duv_x_i,
   input  logic [7:0]       duv_y_i,
   output logic             cmp_valid_o,
   output logic             mismatch_o,
   output logic [3:0]       mismatch_field_o,
   output logic [CNT_W-1:0] mismatch_count_o,
   output logic [31:0]      compare_count_o,
   output logic             overflow_o,
   output logic             timeout_o,
   output logic [1:0]       state_o
`ifdef CPU_CMP_STOP_ON_MISMATCH_EN
   ,
   output logic [31:0]      first_ref_o,
   output logic [31:0]      first_duv_o
`endif
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

   state_e          state_q, state_d;
   snapshot_t       ref_wr, duv_wr, ref_rd, duv_rd;
   logic            ref_full, ref_empty, duv_full, duv_empty;
   logic            run_active, flush, pop;
   logic            ovf_evt, tmo_evt, skew, stop_evt;
   logic [3:0]      diff;
   logic [TW-1:0]   tmo_cnt;

   assign ref_wr = {ref_opcode_i, ref_a_i, ref_x_i, ref_y_i};
   assign duv_wr = {duv_opcode_i, duv_a_i, duv_x_i, duv_y_i};

   // FAULT keeps both FIFOs intact for post-mortem; only IDLE/RUN with enable low flush.
   assign run_active = (state_q == RUN) && enable_i && !clear_i;
   assign flush      = clear_i || ((state_q != FAULT) && !enable_i);
   assign pop        = run_active && !ref_empty && !duv_empty;
   assign ovf_evt    = run_active && ((ref_valid_i && ref_full && !pop) ||
                                      (duv_valid_i && duv_full && !pop));
   assign skew       = run_active && (ref_empty != duv_empty);
   assign tmo_evt    = skew && (tmo_cnt == TMO_LAST);
   assign diff       = field_diff(ref_rd, duv_rd);

`ifdef CPU_CMP_STOP_ON_MISMATCH_EN
   assign stop_evt = pop && (diff != 4'b0000);
`else
   assign stop_evt = 1'b0;
`endif

   cpu_cmp_fifo #(.DEPTH(DEPTH), .WIDTH($bits(snapshot_t))) u_ref_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .push  (run_active && ref_valid_i),
      .pop   (pop),
      .wdata (ref_wr),
      .rdata (ref_rd),
      .full  (ref_full),
      .empty (ref_empty)
   );

   cpu_cmp_fifo #(.DEPTH(DEPTH), .WIDTH($bits(snapshot_t))) u_duv_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .push  (run_active && duv_valid_i),
      .pop   (pop),
      .wdata (duv_wr),
      .rdata (duv_rd),
      .full  (duv_full),
      .empty (duv_empty)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (enable_i) state_d = RUN;
         RUN: begin
            if (!enable_i)                          state_d = IDLE;
            else if (ovf_evt || tmo_evt || stop_evt) state_d = FAULT;
         end
         FAULT:   state_d = FAULT;
         default: state_d = IDLE;
      endcase
      if (clear_i) state_d = IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q          <= IDLE;
         cmp_valid_o      <= 1'b0;
         mismatch_o       <= 1'b0;
         mismatch_field_o <= '0;
         mismatch_count_o <= '0;
         compare_count_o  <= '0;
         overflow_o       <= 1'b0;
         timeout_o        <= 1'b0;
         tmo_cnt          <= '0;
      end else begin
         state_q <= state_d;
         if (clear_i) begin
            cmp_valid_o      <= 1'b0;
            mismatch_o       <= 1'b0;
            mismatch_field_o <= '0;
            mismatch_count_o <= '0;
            compare_count_o  <= '0;
            overflow_o       <= 1'b0;
            timeout_o        <= 1'b0;
            tmo_cnt          <= '0;
         end else begin
            cmp_valid_o <= pop;
            if (pop) begin
               mismatch_o       <= (diff != 4'b0000);
               mismatch_field_o <= diff;
               compare_count_o  <= compare_count_o + 32'd1;
               if ((diff != 4'b0000) && (mismatch_count_o != {CNT_W{1'b1}}))
                  mismatch_count_o <= mismatch_count_o + CNT_W'(1);
            end
            if (ovf_evt) overflow_o <= 1'b1;
            if (tmo_evt) timeout_o  <= 1'b1;
            tmo_cnt <= skew ? tmo_cnt + TW'(1) : '0;
         end
      end
   end

`ifdef CPU_CMP_STOP_ON_MISMATCH_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         first_ref_o <= '0;
         first_duv_o <= '0;
      end else if (clear_i) begin
         first_ref_o <= '0;
         first_duv_o <= '0;
      end else if (stop_evt) begin
         first_ref_o <= ref_rd;
         first_duv_o <= duv_rd;
      end
   end
`endif

   assign state_o = state_q;

endmodule

// File: doc/cpu_lockstep_checker.md
Name: cpu_lockstep_checker

Overview:
Consumes the per-instruction architectural snapshots (opcode, A, X, Y) that the CPU bench interfaces export from the DUV CPU and the reference CPU. Buffers each stream in its own FIFO, so the two cores may retire the same instruction on different cycles. Compares the streams in order and reports mismatches, counts, and fault conditions (overflow, skew timeout). Sits directly downstream of the bench top's DUV/reference signal assignment and feeds coverage and the test-end decision.

Parameters:
DEPTH, 16, entries per side FIFO (power of two, >=2)
TIMEOUT_CYCLES, 1024, max consecutive cycles one side may hold data while the other is empty
CNT_W, 16, width of mismatch counter (saturating)

Ports:
clk  in  1  bench clock
rst_n  in  1  asynchronous active-low reset
enable_i  in  1  checker active; low flushes FIFOs and holds counters
clear_i  in  1  synchronous clear of FIFOs, counters, sticky flags
ref_valid_i  in  1  reference retire strobe, one per instruction
ref_opcode_i  in  8  reference opcode at retire
ref_a_i / ref_x_i / ref_y_i  in  8 each  reference A/X/Y at retire
duv_valid_i  in  1  DUV retire strobe
duv_opcode_i  in  8  DUV opcode at retire
duv_a_i / duv_x_i / duv_y_i  in  8 each  DUV A/X/Y at retire
cmp_valid_o  out  1  one-cycle pulse: a comparison result is presented
mismatch_o  out  1  qualified by cmp_valid_o: records differ
mismatch_field_o  out  4  per-field diff mask {opcode,a,x,y}, bit3=opcode
mismatch_count_o  out  CNT_W  saturating mismatch count
compare_count_o  out  32  total comparisons (wraps)
overflow_o  out  1  sticky: push into full FIFO
timeout_o  out  1  sticky: skew timeout
state_o  out  2  FSM state encoding

Behaviour:
- Reset: all outputs 0, FIFOs empty, state IDLE.
- Snapshot = 32-bit packed {opcode,a,x,y}; push on *_valid_i in RUN only.
- FSM: IDLE -> RUN when enable_i=1; RUN -> IDLE when enable_i=0 (FIFOs flushed, counters/flags held); RUN -> FAULT on overflow or timeout; FAULT exits only via clear_i (-> IDLE) or reset. FAULT: no push, no pop, outputs frozen except cmp_valid_o=0.
- Pop: in RUN, when both FIFOs are non-empty, pop one entry from each in the same cycle. Result is registered: cmp_valid_o, mismatch_o, mismatch_field_o, and counters update the cycle after the pop (latency 1). Throughput is 1 comparison/cycle.
- Push/pop same cycle: allowed on either FIFO. Push into a full FIFO is accepted if that FIFO pops in the same cycle. Otherwise the push is dropped and overflow_o is set -> FAULT next cycle.
- Empty FIFO never pops; pointers wrap modulo DEPTH, and full/empty use an extra pointer bit.
- Timeout counter: increments while exactly one FIFO is non-empty in RUN and resets otherwise. When it reaches TIMEOUT_CYCLES, timeout_o is set -> FAULT.
- mismatch_count_o saturates at 2^CNT_W-1. compare_count_o wraps.
- clear_i has priority over enable_i and over push/pop in the same cycle.
- Async reset mid-operation: immediate return to reset values; in-flight compare is discarded.

Optional Feature:
CPU_CMP_STOP_ON_MISMATCH_EN
- Defined: the first mismatch moves the FSM to FAULT in the same cycle cmp_valid_o/mismatch_o are presented. Two extra 32-bit outputs, first_ref_o/first_duv_o, hold the offending snapshots until clear_i or reset.
- Undefined: mismatches are counted, and comparison continues. first_ref_o/first_duv_o do not exist.

Decomposition:
- Package cpu_cmp_pkg:
  - snapshot_t packed struct
  - state_e enum {IDLE,RUN,FAULT}
  - field-mask bit index constants
- One sub-module: cpu_cmp_fifo (sync FIFO with push/pop/full/empty/flush), instantiated twice.

Test Plan:
- Ref and DUV each push {A9,05,00,00} on the same cycle -> cmp_valid_o pulse 2 cycles after push, mismatch_o=0, compare_count_o=1.
- Ref pushes {A9,05,00,00}, DUV pushes {A9,06,00,00} 3 cycles later -> mismatch_o=1, mismatch_field_o=4'b0100, mismatch_count_o=1.
- Ref pushes 16 entries with DUV silent, then a 17th -> overflow_o=1, state FAULT, no cmp_valid_o.
- Ref pushes 1 entry, DUV silent, TIMEOUT_CYCLES=8 -> timeout_o=1 after 8 cycles, FAULT. Then clear_i -> all flags 0, IDLE.
- Full FIFO plus simultaneous pop and push -> no overflow, occupancy stays 16.
- With CPU_CMP_STOP_ON_MISMATCH_EN: two mismatches queued -> FAULT after the first, mismatch_count_o=1, first_ref_o/first_duv_o hold the first pair.
